mask_alignment: RTL and testbench

MASK_ALIGNMENT -- requirements
Module: mask_alignment

---
 rtl/mask_alignment.sv | 101 ++++++++++
 tb/tb_mask_alignment.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_alignment.sv
// mask_alignment: splits two IEEE-754 binary32 operands into sign, exponent and
// fraction fields, and aligns their hidden-bit-extended mantissas to the larger
// exponent so a later stage can add or subtract them directly.
//
// Ports:
//   clk              rising-edge clock for all state
//   rst              asynchronous active-high reset; clears every output
//   in_valid         A/B carry a new operand pair this cycle
//   A, B             binary32 operands {sign, exp[7:0], mant[22:0]}
//   out_valid        in_valid delayed by one cycle
//   signA/B          sign fields of the last accepted pair
//   exponentA/B      exponent fields of the last accepted pair
//   mantissaA/B      fraction fields of the last accepted pair
//   alignedMantissaA/B  {1, fraction}, the smaller-exponent one shifted right
//   exponentOut      the larger of the two exponents
//
// All outputs are registered with one cycle of latency; data outputs hold while
// in_valid is low. The hidden bit is always 1 (no denormal/Inf/NaN handling).

module mask_alignment (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    output logic        signA,
    output logic        signB,
    output logic [7:0]  exponentA,
    output logic [7:0]  exponentB,
    output logic [22:0] mantissaA,
    output logic [22:0] mantissaB,
    output logic [23:0] alignedMantissaA,
    output logic [23:0] alignedMantissaB,
    output logic [7:0]  exponentOut
);

    // Logical right shift that saturates to zero once the whole 24-bit value
    // has been shifted out; the exponent difference can reach 255.
    function automatic logic [23:0] shr24(input logic [23:0] val, input logic [7:0] amt);
        if (amt >= 8'd24) begin
            return 24'd0;
        end
        return val >> amt[4:0];
    endfunction

    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] ext_a;
    logic [23:0] ext_b;
    logic [23:0] aln_a_d;
    logic [23:0] aln_b_d;
    logic [7:0]  exp_out_d;

    assign exp_a = A[30:23];
    assign exp_b = B[30:23];
    assign ext_a = {1'b1, A[22:0]};
    assign ext_b = {1'b1, B[22:0]};

    always_comb begin
        aln_a_d   = ext_a;
        aln_b_d   = ext_b;
        exp_out_d = exp_a;
        if (exp_a > exp_b) begin
            exp_out_d = exp_a;
            aln_b_d   = shr24(ext_b, exp_a - exp_b);
        end else if (exp_b > exp_a) begin
            exp_out_d = exp_b;
            aln_a_d   = shr24(ext_a, exp_b - exp_a);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid        <= 1'b0;
            signA            <= 1'b0;
            signB            <= 1'b0;
            exponentA        <= 8'd0;
            exponentB        <= 8'd0;
            mantissaA        <= 23'd0;
            mantissaB        <= 23'd0;
            alignedMantissaA <= 24'd0;
            alignedMantissaB <= 24'd0;
            exponentOut      <= 8'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                signA            <= A[31];
                signB            <= B[31];
                exponentA        <= exp_a;
                exponentB        <= exp_b;
                mantissaA        <= A[22:0];
                mantissaB        <= B[22:0];
                alignedMantissaA <= aln_a_d;
                alignedMantissaB <= aln_b_d;
                exponentOut      <= exp_out_d;
            end
        end
    end

endmodule

// File: tb/tb_mask_alignment.sv
// Self-checking bench for mask_alignment: directed vector table, reset corner
// cases and a random back-to-back stream, all checked through a scoreboard queue.

module tb_mask_alignment;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        signA;
    logic        signB;
    logic [7:0]  exponentA;
    logic [7:0]  exponentB;
    logic [22:0] mantissaA;
    logic [22:0] mantissaB;
    logic [23:0] alignedMantissaA;
    logic [23:0] alignedMantissaB;
    logic [7:0]  exponentOut;

    mask_alignment dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .A                (A),
        .B                (B),
        .out_valid        (out_valid),
        .signA            (signA),
        .signB            (signB),
        .exponentA        (exponentA),
        .exponentB        (exponentB),
        .mantissaA        (mantissaA),
        .mantissaB        (mantissaB),
        .alignedMantissaA (alignedMantissaA),
        .alignedMantissaB (alignedMantissaB),
        .exponentOut      (exponentOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sa;
        logic        sb;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [22:0] ma;
        logic [22:0] mb;
        logic [23:0] ama;
        logic [23:0] amb;
        logic [7:0]  eo;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  eo;
        logic [23:0] ama;
        logic [23:0] amb;
    } vec_t;

    exp_t sb_q[$];
    exp_t last;
    exp_t zero;
    int   vectors;
    int   miscompares;

    // Reference alignment: shift one bit at a time, so large differences
    // naturally drain to zero.
    function automatic logic [23:0] ref_shift(input logic [23:0] v, input int n);
        logic [23:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {1'b0, r[23:1]};
        return r;
    endfunction

    function automatic exp_t fields(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.sa  = a[31];
        e.sb  = b[31];
        e.ea  = a[30:23];
        e.eb  = b[30:23];
        e.ma  = a[22:0];
        e.mb  = b[22:0];
        e.ama = 24'd0;
        e.amb = 24'd0;
        e.eo  = 8'd0;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   ia;
        int   ib;
        e  = fields(a, b);
        ia = int'(e.ea);
        ib = int'(e.eb);
        if (ia >= ib) begin
            e.eo  = e.ea;
            e.ama = {1'b1, e.ma};
            e.amb = ref_shift({1'b1, e.mb}, ia - ib);
        end else begin
            e.eo  = e.eb;
            e.amb = {1'b1, e.mb};
            e.ama = ref_shift({1'b1, e.ma}, ib - ia);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".signA"}, 32'(signA), 32'(e.sa));
        chk({tag, ".signB"}, 32'(signB), 32'(e.sb));
        chk({tag, ".exponentA"}, 32'(exponentA), 32'(e.ea));
        chk({tag, ".exponentB"}, 32'(exponentB), 32'(e.eb));
        chk({tag, ".mantissaA"}, 32'(mantissaA), 32'(e.ma));
        chk({tag, ".mantissaB"}, 32'(mantissaB), 32'(e.mb));
        chk({tag, ".alignedMantissaA"}, 32'(alignedMantissaA), 32'(e.ama));
        chk({tag, ".alignedMantissaB"}, 32'(alignedMantissaB), 32'(e.amb));
        chk({tag, ".exponentOut"}, 32'(exponentOut), 32'(e.eo));
    endtask

    // Called at a negedge: drive one cycle, then check the registered result
    // at the following negedge.
    task automatic step(input string tag, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
        exp_t got;
        in_valid = v;
        A        = a;
        B        = b;
        if (v) sb_q.push_back(e);
        vectors++;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
            end else begin
                got  = sb_q.pop_front();
                chk_all(tag, got);
                last = got;
            end
        end else begin
            chk_all({tag, ".hold"}, last);
        end
    endtask

    vec_t vecs[10];

    initial begin
        exp_t e;
        logic [31:0] ra;
        logic [31:0] rb;

        vectors     = 0;
        miscompares = 0;
        zero        = fields(32'd0, 32'd0);
        last        = zero;

        vecs[0] = '{32'h40000000, 32'h3F800000, 8'd128, 24'h800000, 24'h400000};
        vecs[1] = '{32'h3F800000, 32'h41200000, 8'd130, 24'h100000, 24'hA00000};
        vecs[2] = '{32'hBFC00000, 32'h3F800000, 8'd127, 24'hC00000, 24'h800000};
        vecs[3] = '{32'h7F000000, 32'h00000001, 8'd254, 24'h800000, 24'h000000};
        vecs[4] = '{32'h00000000, 32'h00000000, 8'd0,   24'h800000, 24'h800000};
        vecs[5] = '{32'h4B000000, 32'h3F800000, 8'd150, 24'h800000, 24'h000001};
        vecs[6] = '{32'h4B800000, 32'h3F800000, 8'd151, 24'h800000, 24'h000000};
        vecs[7] = '{32'h7F800000, 32'h00000000, 8'd255, 24'h800000, 24'h000000};
        vecs[8] = '{32'h3F800000, 32'h4B7FFFFF, 8'd150, 24'h000001, 24'hFFFFFF};
        vecs[9] = '{32'h3FFFFFFF, 32'h3F7FFFFF, 8'd127, 24'hFFFFFF, 24'h7FFFFF};

        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 32'hFFFFFFFF;
        B        = 32'hFFFFFFFF;
        #1;
        chk("por.out_valid", 32'(out_valid), 32'd0);
        chk_all("por", zero);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            e     = fields(vecs[i].a, vecs[i].b);
            e.eo  = vecs[i].eo;
            e.ama = vecs[i].ama;
            e.amb = vecs[i].amb;
            step($sformatf("vec%0d", i), 1'b1, vecs[i].a, vecs[i].b, e);
        end

        // Data outputs hold while in_valid is low, whatever is on A/B
        step("idle0", 1'b0, 32'h12345678, 32'h9ABCDEF0, zero);
        step("idle1", 1'b0, 32'hDEADBEEF, 32'h0BADF00D, zero);

        // Reset mid-stream with a pair in flight
        step("pre_rst", 1'b1, 32'h40490FDB, 32'hC02DF854, model(32'h40490FDB, 32'hC02DF854));
        in_valid = 1'b1;
        A        = 32'h42F6E979;
        B        = 32'h3DCCCCCD;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async.out_valid", 32'(out_valid), 32'd0);
        chk_all("rst_async", zero);
        @(posedge clk);
        @(negedge clk);
        chk("rst_held.out_valid", 32'(out_valid), 32'd0);
        chk_all("rst_held", zero);
        sb_q.delete();
        last = zero;
        rst  = 1'b0;
        e     = fields(vecs[1].a, vecs[1].b);
        e.eo  = vecs[1].eo;
        e.ama = vecs[1].ama;
        e.amb = vecs[1].amb;
        step("post_rst", 1'b1, vecs[1].a, vecs[1].b, e);
        step("post_rst_idle", 1'b0, 32'h0, 32'h0, zero);

        // Random back-to-back stream; half the time B's exponent is pulled
        // near A's so small differences and ties are well covered.
        for (int i = 0; i < 2048; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                rb[30:23] = ra[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
            end
            step($sformatf("rnd%0d", i), 1'b1, ra, rb, model(ra, rb));
        end
        step("final_idle", 1'b0, 32'h0, 32'h0, zero);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
